// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM behind the memory stage.
// Accepts one access at a time and answers after LATENCY cycles.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      async active-low reset
//   req_i        access request, held while stall_o=1
//   addr_i       byte address
//   wdata_i      store data
//   width_src_i  000 word, 010 half, 001 byte, else word
//   we_i         1 = store, 0 = load
//   rdata_o      aligned 32-bit word, held between responses
//   rsp_valid_o  one-cycle completion pulse
//   stall_o      hold upstream stages
//   misaligned_o completion was misaligned
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  width_src_i,
  input  logic        we_i,
  output logic [31:0] rdata_o,
  output logic        rsp_valid_o,
  output logic        stall_o,
  output logic        misaligned_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_lat
    $error("LATENCY must be 1..15");
  end
  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          mis_q, mis_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem_q [DEPTH];

  logic          is_byte, is_half;
  logic          mis_now;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [AW-1:0] acc_idx;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic [31:0]   merged;
  logic          stall_c;
  logic          rsp_c;
  logic          mis_c;

  // Upper address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:AW+2];

  assign is_byte = (width_src_i == 3'b001);
  assign is_half = (width_src_i == 3'b010);
  assign acc_idx = addr_i[AW+1:2];

  always_comb begin
    be      = 4'b1111;
    wlane   = wdata_i;
    mis_now = (addr_i[1:0] != 2'b00);
    unique case (1'b1)
      is_byte: begin
        be      = 4'b0001 << addr_i[1:0];
        wlane   = {4{wdata_i[7:0]}};
        mis_now = 1'b0;
      end
      is_half: begin
        be      = addr_i[1] ? 4'b1100
                            : 4'b0011;
        wlane   = {2{wdata_i[15:0]}};
        mis_now = addr_i[0];
      end
      default: ;
    endcase
  end

  assign accept = (state_q == IDLE) & req_i;
  assign wr_en  = accept & we_i & ~mis_now;

  // With LATENCY==1 the response word is captured on the same
  // edge as the store, so the store lanes are merged in here.
  assign rd_idx  = accept ? acc_idx : idx_q;
  assign rd_word = mem_q[rd_idx];

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (wr_en && be[b]) begin
        merged[8*b +: 8] = wlane[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    stall_c = 1'b0;
    rsp_c   = 1'b0;
    mis_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          stall_c = 1'b1;
          idx_d   = acc_idx;
          mis_d   = mis_now;
          if (LATENCY == 1) begin
            state_d = RESP;
            rdata_d = mis_now ? 32'h0 : merged;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = mis_q ? 32'h0 : merged;
        end
      end
      RESP: begin
        rsp_c   = 1'b1;
        mis_c   = mis_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is not reset; a store only lands if reset is released.
  always_ff @(posedge clk_i) begin
    if (reset_i && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[acc_idx][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  // Gated so a request held through reset shows no stall.
  assign stall_o      = reset_i & stall_c;
  assign rsp_valid_o  = rsp_c;
  assign misaligned_o = mis_c;
  assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random and directed checks of
// data_mem_responder at LATENCY 1 and 3 against a byte-lane model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam logic [2:0] W_WORD = 3'b000;
  localparam logic [2:0] W_HALF = 3'b010;
  localparam logic [2:0] W_BYTE = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [2:0]  width [2];
  logic        we    [2];
  logic [31:0] rdata [2];
  logic        rsp   [2];
  logic        stall [2];
  logic        mis   [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] model [2][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk_i(clk), .reset_i(rst_n[0]), .req_i(req[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]),
    .width_src_i(width[0]), .we_i(we[0]),
    .rdata_o(rdata[0]), .rsp_valid_o(rsp[0]),
    .stall_o(stall[0]), .misaligned_o(mis[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk_i(clk), .reset_i(rst_n[1]), .req_i(req[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]),
    .width_src_i(width[1]), .we_i(we[1]),
    .rdata_o(rdata[1]), .rsp_valid_o(rsp[1]),
    .stall_o(stall[1]), .misaligned_o(mis[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: byte-lane view of memory, sequential accesses.
  function automatic void ref_access(
    input int d, input logic [31:0] a, input logic [31:0] wd,
    input logic [2:0] w, input logic wv,
    output logic [31:0] er, output logic em);
    int idx, off, nb;
    idx = int'((a >> 2) % DEPTH);
    off = int'(a % 4);
    nb  = (w == W_BYTE) ? 1 : (w == W_HALF) ? 2 : 4;
    em  = (off % nb) != 0;
    er  = '0;
    if (em) return;
    if (wv) begin
      for (int i = 0; i < nb; i++)
        model[d][idx][8*(off+i) +: 8] = wd[8*i +: 8];
    end
    er = model[d][idx];
  endfunction

  // Starts at posedge+1 with DUT idle, returns at posedge+1 after
  // the response cycle with req still held.
  task automatic access(
    input int d, input logic [31:0] a, input logic [31:0] wd,
    input logic [2:0] w, input logic wv,
    output logic [31:0] rd, output logic mv, output int lat,
    output int stalls, output logic rs, output bit got);
    req[d] = 1'b1; addr[d] = a; wdata[d] = wd;
    width[d] = w; we[d] = wv;
    lat = 0; stalls = 0; got = 0; rd = '0; mv = 1'b0; rs = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp[d]) begin
        got = 1; rd = rdata[d]; mv = mis[d]; rs = stall[d];
      end else begin
        lat++;
        if (stall[d]) stalls++;
      end
      @(posedge clk); #1;
      if (got) break;
    end
  endtask

  task automatic go_idle(input int d);
    req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd, er; logic mv, em, rs; int lt, st; bit got;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rdata[d], rsp[d], stall[d], mis[d]} !== 35'h0) begin
        errors++;
        $display("FAIL reset_outputs d=%0d: got %h/%b/%b/%b required 0",
                 d, rdata[d], rsp[d], stall[d], mis[d]);
      end
      req[d] = 1'b1; #1;
      checks++;
      if (stall[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall_gated d=%0d: got %b required 0", d, stall[d]);
      end
      req[d] = 1'b0;
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;
    ref_access(1, 32'h40, 32'hCAFEF00D, W_WORD, 1'b1, er, em);
    access(1, 32'h40, 32'hCAFEF00D, W_WORD, 1'b1, rd, mv, lt, st, rs, got);
    access(1, 32'h40, 32'h0, W_WORD, 1'b0, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL pre_reset_load: got %h (rsp=%0d) required cafef00d", rd, got);
    end
    @(posedge clk); #2;
    checks++;
    if (stall[1] !== 1'b1) begin
      errors++;
      $display("FAIL wait_stall: got %b required 1", stall[1]);
    end
    rst_n[1] = 1'b0; #1;
    checks++;
    if ({rdata[1], rsp[1], stall[1], mis[1]} !== 35'h0) begin
      errors++;
      $display("FAIL midwait_reset: got %h/%b/%b/%b required 0",
               rdata[1], rsp[1], stall[1], mis[1]);
    end
    req[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (stall[1] !== 1'b0 || rsp[1] !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: stall=%b rsp=%b required 0/0",
                 stall[1], rsp[1]);
      end
    end
    @(posedge clk); #1;
    access(1, 32'h40, 32'h0, W_WORD, 1'b0, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || lt != 3 || st != 3 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL post_reset_load: rd=%h lat=%0d stalls=%0d required cafef00d/3/3",
               rd, lt, st);
    end
    go_idle(1);
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd, er; logic mv, em, rs; int lt, st; bit got;
    ref_access(0, 32'h10, 32'hDEADBEEF, W_WORD, 1'b1, er, em);
    access(0, 32'h10, 32'hDEADBEEF, W_WORD, 1'b1, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || lt != 1 || st != 1 || rs !== 1'b0) begin
      errors++;
      $display("FAIL l1_store_timing: rsp=%0d lat=%0d stalls=%0d rsp_stall=%b required 1/1/1/0",
               got, lt, st, rs);
    end
    checks++;
    if (rd !== er || mv !== 1'b0) begin
      errors++;
      $display("FAIL l1_store_rdata: got %h/%b required %h/0", rd, mv, er);
    end
    go_idle(0);
    access(0, 32'h10, 32'h0, W_WORD, 1'b0, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || lt != 1 || st != 1 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL l1_load: rd=%h lat=%0d stalls=%0d required deadbeef/1/1",
               rd, lt, st);
    end
    go_idle(0);
  endtask

  task automatic test_subword();
    logic [31:0] rd, er; logic mv, em, rs; int lt, st; bit got;
    ref_access(0, 32'h11, 32'h000000AA, W_BYTE, 1'b1, er, em);
    access(0, 32'h11, 32'h000000AA, W_BYTE, 1'b1, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || rd !== er) begin
      errors++;
      $display("FAIL byte_store_rsp: got %h required %h", rd, er);
    end
    ref_access(0, 32'h12, 32'h00001234, W_HALF, 1'b1, er, em);
    access(0, 32'h12, 32'h00001234, W_HALF, 1'b1, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || rd !== er) begin
      errors++;
      $display("FAIL half_store_rsp: got %h required %h", rd, er);
    end
    access(0, 32'h10, 32'h0, W_WORD, 1'b0, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || rd !== 32'h1234AAEF) begin
      errors++;
      $display("FAIL subword_merge: got %h required 1234aaef", rd);
    end
    go_idle(0);
  endtask

  task automatic test_latency3();
    logic [31:0] rd, er, wd; logic mv, em, rs; int lt, st; bit got;
    wd = $urandom;
    ref_access(1, 32'h80, wd, W_WORD, 1'b1, er, em);
    access(1, 32'h80, wd, W_WORD, 1'b1, rd, mv, lt, st, rs, got);
    go_idle(1);
    ref_access(1, 32'h80, 32'h0, W_WORD, 1'b0, er, em);
    access(1, 32'h80, 32'h0, W_WORD, 1'b0, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || lt != 3 || st != 3 || rs !== 1'b0) begin
      errors++;
      $display("FAIL l3_timing: rsp=%0d lat=%0d stalls=%0d rsp_stall=%b required 1/3/3/0",
               got, lt, st, rs);
    end
    checks++;
    if (rd !== er) begin
      errors++;
      $display("FAIL l3_rdata: got %h required %h", rd, er);
    end
    req[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (stall[1] !== 1'b0 || rsp[1] !== 1'b0) begin
        errors++;
        $display("FAIL l3_no_reaccept: stall=%b rsp=%b required 0/0",
                 stall[1], rsp[1]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, er; logic mv, em, rs; int lt, st; bit got;
    ref_access(0, 32'h20, 32'h11223344, W_WORD, 1'b1, er, em);
    access(0, 32'h20, 32'h11223344, W_WORD, 1'b1, rd, mv, lt, st, rs, got);
    ref_access(0, 32'h22, 32'hA5A5A5A5, W_WORD, 1'b1, er, em);
    access(0, 32'h22, 32'hA5A5A5A5, W_WORD, 1'b1, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || mv !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL mis_word_store: mis=%b rd=%h required 1/00000000", mv, rd);
    end
    access(0, 32'h13, 32'h0, W_HALF, 1'b0, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || mv !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL mis_half_load: mis=%b rd=%h required 1/00000000", mv, rd);
    end
    access(0, 32'h23, 32'h0, W_BYTE, 1'b0, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || mv !== 1'b0 || rd !== 32'h11223344) begin
      errors++;
      $display("FAIL byte_not_mis: mis=%b rd=%h required 0/11223344", mv, rd);
    end
    go_idle(0);
    @(negedge clk);
    checks++;
    if (mis[0] !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse_only: got %b required 0", mis[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alias();
    logic [31:0] rd, er; logic mv, em, rs; int lt, st; bit got;
    ref_access(0, 32'h1000, 32'h55, W_WORD, 1'b1, er, em);
    access(0, 32'h1000, 32'h55, W_WORD, 1'b1, rd, mv, lt, st, rs, got);
    access(0, 32'h0000, 32'h0, W_WORD, 1'b0, rd, mv, lt, st, rs, got);
    checks++;
    if (!got || rd !== 32'h00000055) begin
      errors++;
      $display("FAIL alias_load: got %h required 00000055", rd);
    end
    go_idle(0);
  endtask

  task automatic test_random();
    logic [31:0] rd, er, a, wd; logic mv, em, rs, wv;
    logic [2:0] w; int lt, st; bit got;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        a = 32'h100 + 32'(i * 4);
        ref_access(d, a, wd, W_WORD, 1'b1, er, em);
        access(d, a, wd, W_WORD, 1'b1, rd, mv, lt, st, rs, got);
      end
      go_idle(d);
      for (int i = 0; i < 40; i++) begin
        a  = 32'h100 + $urandom_range(0, 63) + ($urandom_range(0, 7) << 12);
        wd = $urandom;
        wv = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: w = W_WORD;
          1: w = W_HALF;
          2: w = W_BYTE;
          default: w = 3'($urandom_range(0, 7));
        endcase
        ref_access(d, a, wd, w, wv, er, em);
        access(d, a, wd, w, wv, rd, mv, lt, st, rs, got);
        checks++;
        if (!got || lt != lat_of(d) || st != lat_of(d) || rs !== 1'b0) begin
          errors++;
          $display("FAIL rand_timing d=%0d a=%h: lat=%0d stalls=%0d rsp_stall=%b required %0d/%0d/0",
                   d, a, lt, st, rs, lat_of(d), lat_of(d));
        end
        checks++;
        if (rd !== er || mv !== em) begin
          errors++;
          $display("FAIL rand_data d=%0d a=%h w=%b we=%b: got %h/%b required %h/%b",
                   d, a, w, wv, rd, mv, er, em);
        end
        if ($urandom_range(0, 1) == 1) go_idle(d);
      end
      go_idle(d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, er, a, wd; logic mv, em, rs, wv;
    int lt, st, t0, nerr; bit got;
    for (int d = 0; d < 2; d++) begin
      t0 = cyc;
      nerr = 0;
      for (int i = 0; i < 6; i++) begin
        a  = 32'h100 + 32'($urandom_range(0, 15) * 4);
        wd = $urandom;
        wv = (i % 2 == 0);
        ref_access(d, a, wd, W_WORD, wv, er, em);
        access(d, a, wd, W_WORD, wv, rd, mv, lt, st, rs, got);
        checks++;
        if (!got || rd !== er) begin
          errors++;
          $display("FAIL b2b_data d=%0d a=%h: got %h required %h", d, a, rd, er);
        end
      end
      checks++;
      if (cyc - t0 != 6 * (lat_of(d) + 1)) begin
        errors++;
        $display("FAIL b2b_throughput d=%0d: got %0d cycles required %0d",
                 d, cyc - t0, 6 * (lat_of(d) + 1));
      end
      go_idle(d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; req[d] = 1'b0; addr[d] = '0;
      wdata[d] = '0; width[d] = W_WORD; we[d] = 1'b0;
    end
    #1;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #2;
    test_reset();
    test_word_store_load();
    test_subword();
    test_latency3();
    test_misaligned();
    test_alias();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder that services the datapath's memory-stage requests: address, store data, width code and write enable.
- Returns full 32-bit read words after a programmable latency. Sub-word extraction stays in the memory stage.
- Holds the pipeline via stall_o while an access is outstanding. Flags misaligned accesses.
- Internal word-addressed RAM, DEPTH words.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, >=4
LATENCY, 1, cycles from acceptance to response; legal range 1..15

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  asynchronous active-low reset (0 = in reset)
req_i  input  1  access request valid; held stable by the pipeline while stall_o=1
addr_i  input  32  byte address (alu_result_m)
wdata_i  input  32  store data (write_data_m)
width_src_i  input  3  access width: 3'b000 word, 3'b010 halfword, 3'b001 byte; other codes treated as word
we_i  input  1  1 = store, 0 = load
rdata_o  output  32  aligned read word containing the addressed byte/half
rsp_valid_o  output  1  one-cycle pulse: access complete, rdata_o valid
stall_o  output  1  to hazard unit: hold F/D/E/M stages
misaligned_o  output  1  pulses with rsp_valid_o when the completed access was misaligned

Behaviour:
- Reset (reset_i=0, asynchronous):
  - State goes to IDLE, counter 0.
  - rdata_o=0, rsp_valid_o=0, stall_o=0, misaligned_o=0.
  - RAM contents are not reset.
- Reset asserted mid-access abandons the access. A store already committed stays committed.
- Word index = addr_i[log2(DEPTH)+1:2]. Upper address bits are ignored, so out-of-range addresses alias (wrap).
- Misaligned: word with addr_i[1:0]!=0, or halfword with addr_i[0]=1. Misaligned accesses never write; their response has rdata_o=0 and misaligned_o=1.
- FSM states: IDLE, WAIT, RESP.
  - IDLE & req_i (cycle T):
    - Accept the request and latch addr, width, we, misaligned flag.
    - stall_o=1 combinationally in T.
    - Next state: RESP if LATENCY==1, else WAIT with cnt=LATENCY-1.
  - WAIT: stall_o=1; cnt decrements each cycle; when cnt==1, next state is RESP.
  - RESP (cycle T+LATENCY): rsp_valid_o=1, stall_o=0, misaligned_o=latched flag; next state IDLE unconditionally.
  - The held req_i seen during RESP is the same request and is not re-accepted.
- Throughput: one access per LATENCY+1 cycles. Each request sees exactly LATENCY stall cycles.
- Store commit:
  - Occurs at the rising edge ending cycle T, using byte lanes from width and addr_i[1:0].
  - Byte: wdata_i[7:0] into lane addr_i[1:0].
  - Halfword: wdata_i[15:0] into lanes {addr_i[1],0} and {addr_i[1],1}.
  - Word: all lanes.
  - Unwritten lanes are preserved.
- Load data:
  - Registered; the RAM word is read at the latched index and presented in the RESP cycle.
  - rdata_o holds its value after RESP until the next response.
  - A store response returns the post-write word.
- Load following a store to the same word returns the updated data; accesses are strictly sequential.
- req_i=0 in IDLE: stay in IDLE, all pulses 0, stall_o=0.

Test Plan:
1. Reset with reset_i=0 mid-WAIT (LATENCY=3) -> outputs immediately 0, state IDLE; after release, an idle req_i=0 keeps stall_o=0.
2. LATENCY=1: store word 0xDEADBEEF @0x10, then load @0x10 -> each request stall_o=1 for 1 cycle, then rsp_valid_o=1; load rdata_o=0xDEADBEEF.
3. Byte store 0x000000AA @0x11, then halfword store 0x00001234 @0x12 over word 0xDEADBEEF, load @0x10 -> rdata_o=0x1234AAEF.
4. LATENCY=3: load -> stall_o high exactly 3 cycles, rsp_valid_o single pulse in 4th cycle, no re-acceptance of the held request.
5. Word store @0x22 and halfword load @0x13 -> misaligned_o=1 with rsp_valid_o, rdata_o=0, word @0x20 unchanged.
6. DEPTH=1024: store 0x55 @0x1000 then load @0x0000 -> aliased word returns 0x00000055.
